// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg
//   Shared types for the SPI-to-RAM bridge.
//   cmd_e   : 2-bit frame command, sent MSB first at the start of every frame
//   state_e : bridge frame-sequencing states
//   max_int : elaboration-time helper used to size shared registers
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PAYLOAD,
    RD_WAIT,
    RD_SHIFT,
    DONE
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_ram_bridge_if.sv
// spi_ram_bridge_if
//   Serial-side signal bundle of the SPI-to-RAM bridge.
//   SS_n     : slave select, active low (master -> slave)
//   MOSI     : serial data in, MSB first (master -> slave)
//   MISO     : registered serial data out (slave -> master)
//   busy     : frame in progress (slave -> master)
//   addr_err : sticky out-of-range access flag (slave -> master)
interface spi_ram_bridge_if;

  logic SS_n;
  logic MOSI;
  logic MISO;
  logic busy;
  logic addr_err;

  modport master (output SS_n, MOSI, input MISO, busy, addr_err);
  modport slave  (input SS_n, MOSI, output MISO, busy, addr_err);

endinterface

// File: rtl/spi_ram_mem.sv
// spi_ram_mem
//   Single-port synchronous RAM, DATA_W x DEPTH, with a one-cycle registered
//   read. Addresses at or beyond DEPTH never write and read back as zero, so
//   the caller does not need to mask out-of-range accesses itself.
//   clk  : clock
//   we   : write enable (write has priority over read)
//   re   : read enable, dout updates on the same edge
//   addr : word address
//   din  : write data
//   dout : registered read data
module spi_ram_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign in_range = {1'b0, addr} < DEPTH_V;
  assign idx      = addr[IDX_W-1:0];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[idx] <= din;
    end else if (re) begin
      dout <= in_range ? mem[idx] : '0;
    end
  end

endmodule

// File: rtl/spi_ram_bridge.sv
// spi_ram_bridge
//   SPI-slave front end onto an on-chip RAM. Each SS_n-low frame starts with
//   a 2-bit command, then either an address/data payload (shifted in MSB
//   first) or, for reads, a wait cycle followed by DATA_W bits shifted out.
//   clk      : clock, all logic on the rising edge
//   rst      : synchronous active-high reset
//   bus      : serial interface (SS_n, MOSI in; MISO, busy, addr_err out)
module spi_ram_bridge
  import spi_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst,
  spi_ram_bridge_if.slave   bus
);

  localparam int SH_W  = max_int(DATA_W, ADDR_W);
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  DATA_CNT  = CNT_W'(DATA_W);

  state_e            state, state_nx;
  logic [1:0]        cmd_r;
  logic [1:0]        cmd_now;
  logic [CNT_W-1:0]  cnt;
  logic [SH_W-1:0]   sh_in;
  logic [SH_W-1:0]   word_in;
  logic [DATA_W-1:0] sh_out;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [ADDR_W-1:0] wr_inc, rd_inc;
  logic              miso_r, err_r;
  logic              final_bit;
  logic              wr_ok, rd_ok, val_ok;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;

  // The command is only complete on the second edge, so the CMD state looks
  // at the stored first bit together with the live MOSI bit.
  assign cmd_now = {cmd_r[0], bus.MOSI};
  assign word_in = {sh_in[SH_W-2:0], bus.MOSI};

  assign wr_ok  = {1'b0, wr_addr} < DEPTH_V;
  assign rd_ok  = {1'b0, rd_addr} < DEPTH_V;
  assign val_ok = {1'b0, word_in[ADDR_W-1:0]} < DEPTH_V;

  assign wr_inc = (wr_addr == LAST_A) ? '0 : wr_addr + ADDR_W'(1);
  assign rd_inc = (rd_addr == LAST_A) ? '0 : rd_addr + ADDR_W'(1);

  // Last payload bit is being sampled on this edge and the frame is intact.
  always_comb begin
    final_bit = 1'b0;
    if (state == PAYLOAD && !bus.SS_n) begin
      if (cmd_r == CMD_WR_DATA) final_bit = (cnt == DATA_LAST);
      else                      final_bit = (cnt == ADDR_LAST);
    end
  end

  assign mem_we   = final_bit && (cmd_r == CMD_WR_DATA) && wr_ok;
  assign mem_re   = (state == RD_WAIT) && !bus.SS_n;
  assign mem_addr = mem_we ? wr_addr : rd_addr;

  spi_ram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .din  (word_in[DATA_W-1:0]),
    .dout (mem_dout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // SS_n high in any active state ends the frame; a completed frame parks
  // in DONE until the master releases SS_n.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (!bus.SS_n) state_nx = CMD;
      CMD: begin
        if (bus.SS_n)                    state_nx = IDLE;
        else if (cmd_now == CMD_RD_DATA) state_nx = RD_WAIT;
        else                             state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        if (bus.SS_n)      state_nx = IDLE;
        else if (final_bit) state_nx = DONE;
      end
      RD_WAIT:  state_nx = bus.SS_n ? IDLE : RD_SHIFT;
      RD_SHIFT: begin
        if (bus.SS_n)             state_nx = IDLE;
        else if (cnt == DATA_CNT) state_nx = DONE;
      end
      DONE:     if (bus.SS_n) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_r   <= '0;
      cnt     <= '0;
      sh_in   <= '0;
      sh_out  <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
      miso_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_r <= {1'b0, bus.MOSI};
          cnt   <= '0;
          sh_in <= '0;
        end
        CMD: begin
          cmd_r <= cmd_now;
          cnt   <= '0;
          sh_in <= '0;
        end
        PAYLOAD: begin
          if (!bus.SS_n) begin
            sh_in <= word_in;
            cnt   <= cnt + CNT_W'(1);
          end
          if (final_bit) begin
            case (cmd_r)
              CMD_WR_ADDR: begin
                wr_addr <= word_in[ADDR_W-1:0];
                if (!val_ok) err_r <= 1'b1;
              end
              CMD_RD_ADDR: begin
                rd_addr <= word_in[ADDR_W-1:0];
                if (!val_ok) err_r <= 1'b1;
              end
              CMD_WR_DATA: begin
                if (!wr_ok)              err_r   <= 1'b1;
                else if (AUTO_INC != 0)  wr_addr <= wr_inc;
              end
              default: ;
            endcase
          end
        end
        RD_WAIT: begin
          // The RAM read of rd_addr is launched on this edge.
          if (!bus.SS_n) begin
            cnt <= '0;
            if (!rd_ok)             err_r   <= 1'b1;
            else if (AUTO_INC != 0) rd_addr <= rd_inc;
          end
        end
        RD_SHIFT: begin
          if (!bus.SS_n) begin
            if (cnt == '0) begin
              miso_r <= mem_dout[DATA_W-1];
              sh_out <= mem_dout << 1;
            end else if (cnt == DATA_CNT) begin
              miso_r <= 1'b0;
            end else begin
              miso_r <= sh_out[DATA_W-1];
              sh_out <= sh_out << 1;
            end
            if (cnt != DATA_CNT) cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
      if (state != IDLE && bus.SS_n) miso_r <= 1'b0;
    end
  end

  assign bus.MISO     = miso_r;
  assign bus.busy     = (state != IDLE);
  assign bus.addr_err = err_r;

endmodule

// File: tb/tb_spi_ram_bridge.sv
// tb_spi_ram_bridge
//   Directed plus randomized bench for spi_ram_bridge. Two instances are
//   used: index 1 with AUTO_INC=1 and index 0 with AUTO_INC=0, each with its
//   own reset. A frame-level reference model tracks RAM, addresses and the
//   error flag.
module tb_spi_ram_bridge;
  import spi_ram_pkg::*;

  localparam int DEPTH = 200;

  logic clk = 1'b0;
  logic rst, rst0;
  always #5 clk = ~clk;

  spi_ram_bridge_if bus1 ();
  spi_ram_bridge_if bus0 ();

  spi_ram_bridge #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .AUTO_INC(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );
  spi_ram_bridge #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .AUTO_INC(0)) dut0 (
    .clk (clk), .rst (rst0), .bus (bus0.slave)
  );

  int checks = 0;
  int passes = 0;

  // Reference model, indexed by instance
  logic [7:0] m_mem [2][DEPTH];
  int         m_wr  [2];
  int         m_rd  [2];
  logic       m_err [2];
  int         m_ai  [2] = '{0, 1};

  task automatic model_reset(input int s);
    m_wr[s] = 0; m_rd[s] = 0; m_err[s] = 1'b0;
  endtask

  task automatic set_ss(input int s, input logic v);
    if (s == 1) bus1.SS_n = v; else bus0.SS_n = v;
  endtask

  task automatic set_mosi(input int s, input logic v);
    if (s == 1) bus1.MOSI = v; else bus0.MOSI = v;
  endtask

  function automatic logic get_miso(input int s);
    return (s == 1) ? bus1.MISO : bus0.MISO;
  endfunction
  function automatic logic get_busy(input int s);
    return (s == 1) ? bus1.busy : bus0.busy;
  endfunction
  function automatic logic get_err(input int s);
    return (s == 1) ? bus1.addr_err : bus0.addr_err;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one MOSI bit, let the DUT sample it, return at the next negedge.
  task automatic applyStimulus(input int s, input logic b);
    set_mosi(s, b);
    @(negedge clk);
  endtask

  task automatic start_frame(input int s, input logic [1:0] cmd);
    set_ss(s, 1'b0);
    applyStimulus(s, cmd[1]);
    applyStimulus(s, cmd[0]);
  endtask

  task automatic end_frame(input int s);
    set_ss(s, 1'b1);
    set_mosi(s, 1'b0);
    @(negedge clk);
    checkOutput("busy_after_frame", get_busy(s), 1'b0);
    checkOutput("addr_err", get_err(s), m_err[s]);
  endtask

  task automatic wr_frame(input int s, input logic [1:0] cmd, input logic [7:0] val);
    start_frame(s, cmd);
    for (int i = 7; i >= 0; i--) applyStimulus(s, val[i]);
    case (cmd)
      2'b00: begin m_wr[s] = val; if (val >= DEPTH) m_err[s] = 1'b1; end
      2'b10: begin m_rd[s] = val; if (val >= DEPTH) m_err[s] = 1'b1; end
      2'b01: begin
        if (m_wr[s] < DEPTH) begin
          m_mem[s][m_wr[s]] = val;
          if (m_ai[s] != 0) m_wr[s] = (m_wr[s] + 1) % DEPTH;
        end else m_err[s] = 1'b1;
      end
      default: ;
    endcase
    end_frame(s);
  endtask

  task automatic rd_frame(input int s, input string tag);
    logic [7:0] got, exp;
    start_frame(s, 2'b11);
    applyStimulus(s, 1'($urandom));
    checkOutput("miso_before_data", get_miso(s), 1'b0);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(s, 1'($urandom));
      got[i] = get_miso(s);
    end
    applyStimulus(s, 1'($urandom));
    checkOutput("miso_after_data", get_miso(s), 1'b0);
    if (m_rd[s] < DEPTH) begin
      exp = m_mem[s][m_rd[s]];
      if (m_ai[s] != 0) m_rd[s] = (m_rd[s] + 1) % DEPTH;
    end else begin
      exp = 8'h00;
      m_err[s] = 1'b1;
    end
    checkOutput(tag, got, exp);
    end_frame(s);
  endtask

  task automatic abort_frame(input int s, input logic [1:0] cmd, input int nbits);
    start_frame(s, cmd);
    for (int i = 0; i < nbits; i++) applyStimulus(s, 1'($urandom));
    set_ss(s, 1'b1);
    @(negedge clk);
    checkOutput("busy_after_abort", get_busy(s), 1'b0);
    checkOutput("miso_after_abort", get_miso(s), 1'b0);
  endtask

  int addr_q [$];

  initial begin
    $display("[TB] start");
    rst = 1'b1; rst0 = 1'b1;
    bus1.SS_n = 1'b0; bus0.SS_n = 1'b0;
    bus1.MOSI = 1'b0; bus0.MOSI = 1'b0;
    model_reset(0); model_reset(1);

    // Reset held two cycles with an active-looking bus
    for (int c = 0; c < 2; c++) begin
      bus0.MOSI = ~bus0.MOSI;
      applyStimulus(1, ~bus1.MOSI);
      for (int s = 0; s < 2; s++) begin
        checkOutput("reset_miso", get_miso(s), 1'b0);
        checkOutput("reset_busy", get_busy(s), 1'b0);
        checkOutput("reset_err",  get_err(s),  1'b0);
      end
    end
    rst = 1'b0; rst0 = 1'b0;
    bus1.SS_n = 1'b1; bus0.SS_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic write/read");
    wr_frame(1, 2'b00, 8'h10);
    wr_frame(1, 2'b01, 8'hA5);
    wr_frame(1, 2'b10, 8'h10);
    rd_frame(1, "rd_0x10_A5");

    $display("[TB] burst with wrap");
    wr_frame(1, 2'b00, 8'hC6);
    wr_frame(1, 2'b01, 8'h11);
    wr_frame(1, 2'b01, 8'h22);
    wr_frame(1, 2'b01, 8'h33);
    wr_frame(1, 2'b10, 8'hC6);
    rd_frame(1, "burst_rd_198");
    rd_frame(1, "burst_rd_199");
    rd_frame(1, "burst_rd_0");

    $display("[TB] abort");
    wr_frame(1, 2'b00, 8'h05);
    wr_frame(1, 2'b01, 8'h3C);
    wr_frame(1, 2'b01, 8'h4D);
    wr_frame(1, 2'b00, 8'h05);
    abort_frame(1, 2'b01, 5);
    wr_frame(1, 2'b10, 8'h05);
    rd_frame(1, "abort_ram5_kept");
    wr_frame(1, 2'b01, 8'h77);
    wr_frame(1, 2'b10, 8'h05);
    rd_frame(1, "abort_wr_addr_kept");
    rd_frame(1, "abort_ram6_kept");

    $display("[TB] random traffic");
    for (int n = 0; n < 12; n++) begin
      int a;
      a = $urandom_range(DEPTH - 1);
      addr_q.push_back(a);
      wr_frame(1, 2'b00, 8'(a));
      wr_frame(1, 2'b01, 8'($urandom));
    end
    for (int n = 0; n < 12; n++) begin
      wr_frame(1, 2'b10, 8'(addr_q[$urandom_range(addr_q.size() - 1)]));
      rd_frame(1, "random_rd");
    end

    $display("[TB] out of range");
    wr_frame(1, 2'b00, 8'hD0);
    wr_frame(1, 2'b01, 8'hFF);
    wr_frame(1, 2'b10, 8'hD0);
    rd_frame(1, "oor_read_zero");
    wr_frame(1, 2'b10, 8'h10);
    rd_frame(1, "after_oor_rd_0x10");

    $display("[TB] no auto increment");
    wr_frame(0, 2'b00, 8'h10);
    wr_frame(0, 2'b01, 8'($urandom));
    wr_frame(0, 2'b01, 8'($urandom));
    wr_frame(0, 2'b10, 8'h10);
    rd_frame(0, "noinc_rd_first");
    rd_frame(0, "noinc_rd_second");

    $display("[TB] reset mid write");
    wr_frame(0, 2'b00, 8'h20);
    wr_frame(0, 2'b01, 8'h5A);
    start_frame(0, 2'b01);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1);
    rst0 = 1'b1;
    applyStimulus(0, 1'b1);
    rst0 = 1'b0;
    set_ss(0, 1'b1);
    model_reset(0);
    @(negedge clk);
    checkOutput("rst_mid_busy", get_busy(0), 1'b0);
    checkOutput("rst_mid_err",  get_err(0),  1'b0);
    wr_frame(0, 2'b10, 8'h20);
    rd_frame(0, "rst_mid_no_write");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
